subneg_core_param: RTL

//  Parametrised SUBNEG (subtract-and-branch-if-negative) one-instruction CPU core

---
 rtl/subneg_core_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/subneg_core_param.sv
// SUBNEG one-instruction core with a latched, multiplexed address/data bus.
// Build macro SUBNEG_OUTPORT_EN diverts writes to IO_ADDR into out_port.
module subneg_core_param #(
  parameter int unsigned  W        = 8,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter logic [W-1:0] IO_ADDR  = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] bus_in,
  output logic [W-1:0] bus_out,
  output logic [W-1:0] bus_oe,
  output logic         le,
  output logic         moe,
  output logic         mwe,
  output logic [W-1:0] out_port,
  output logic         halted
);

`ifdef SUBNEG_OUTPORT_EN
  localparam bit OutportEn = 1'b1;
`else
  localparam bit OutportEn = 1'b0;
`endif

  typedef enum logic [2:0] {StFa, StFb, StFc, StRa, StRb, StEx, StWr, StHalt} state_e;
  typedef enum logic [1:0] {PhT1, PhT2, PhT3} phase_e;

  state_e       st_q;
  phase_e       ph_q;
  logic [W-1:0] pc_q, a_q, b_q, c_q, val_a_q, val_b_q, r_q;
  logic [W-1:0] rd_addr, pc_next;
  logic         taken, self_branch, io_hit;

  always_comb begin
    case (st_q)
      StFa:    rd_addr = pc_q;
      StFb:    rd_addr = pc_q + W'(1);
      StFc:    rd_addr = pc_q + W'(2);
      StRa:    rd_addr = a_q;
      default: rd_addr = b_q;
    endcase
  end

  assign taken       = r_q[W-1];
  assign pc_next     = taken ? c_q : pc_q + W'(3);
  assign self_branch = taken && (c_q == pc_q);
  assign io_hit      = OutportEn && (b_q == IO_ADDR);

  // (st_q, ph_q) names the bus phase whose outputs are presented after the next
  // enabled edge; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= StFa;
      ph_q     <= PhT1;
      pc_q     <= RESET_PC;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      val_a_q  <= '0;
      val_b_q  <= '0;
      r_q      <= '0;
      bus_out  <= '0;
      bus_oe   <= '0;
      le       <= 1'b0;
      moe      <= 1'b0;
      mwe      <= 1'b0;
      out_port <= '0;
      halted   <= 1'b0;
    end else if (ena) begin
      unique case (st_q)
        StFa, StFb, StFc, StRa, StRb: begin
          unique case (ph_q)
            PhT1: begin
              bus_out <= rd_addr;
              bus_oe  <= '1;
              le      <= 1'b1;
              ph_q    <= PhT2;
            end
            PhT2: begin
              le     <= 1'b0;
              bus_oe <= '0;
              moe    <= 1'b1;
              ph_q   <= PhT3;
            end
            default: begin
              // Memory drives bus_in throughout the moe cycle; sample it as moe drops.
              moe  <= 1'b0;
              ph_q <= PhT1;
              case (st_q)
                StFa: begin
                  a_q  <= bus_in;
                  st_q <= StFb;
                end
                StFb: begin
                  b_q  <= bus_in;
                  st_q <= StFc;
                end
                StFc: begin
                  c_q  <= bus_in;
                  st_q <= StRa;
                end
                StRa: begin
                  val_a_q <= bus_in;
                  st_q    <= StRb;
                end
                default: begin
                  val_b_q <= bus_in;
                  st_q    <= StEx;
                end
              endcase
            end
          endcase
        end
        StEx: begin
          r_q  <= val_b_q - val_a_q;
          st_q <= StWr;
          ph_q <= PhT1;
        end
        StWr: begin
          if (io_hit) begin
            out_port <= r_q;
            pc_q     <= pc_next;
            ph_q     <= PhT1;
            st_q     <= self_branch ? StHalt : StFa;
          end else begin
            unique case (ph_q)
              PhT1: begin
                bus_out <= b_q;
                bus_oe  <= '1;
                le      <= 1'b1;
                ph_q    <= PhT2;
              end
              PhT2: begin
                le      <= 1'b0;
                bus_out <= r_q;
                mwe     <= 1'b1;
                ph_q    <= PhT3;
              end
              default: begin
                // Data stays on the bus through T3 for hold time after mwe falls.
                mwe  <= 1'b0;
                pc_q <= pc_next;
                ph_q <= PhT1;
                st_q <= self_branch ? StHalt : StFa;
              end
            endcase
          end
        end
        default: begin
          bus_out <= '0;
          bus_oe  <= '0;
          le      <= 1'b0;
          moe     <= 1'b0;
          mwe     <= 1'b0;
          halted  <= 1'b1;
        end
      endcase
    end
  end

endmodule
